pc_branch_unit: RTL and testbench

Fetch-side program-counter register and branch resolver for the RV32I core. It consumes the execute-stage ALU flags (`zero`, `signedsmaller`, `unsignedsmaller`) and `ALUResult` for the instruction in EX. It decides taken/not-taken for conditional branches, JAL and JALR, and redirects the PC. It flushes younger instructions and halts the core on a misaligned control-transfer target.

---
 rtl/pc_branch_unit.sv | 134 +++++++++++++
 tb/tb_pc_branch_unit.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pc_branch_unit.sv
// Fetch PC register and EX-stage branch/jump resolver for the RV32I core.
// Redirects fetch on taken transfers and halts on a misaligned target.
module pc_branch_unit #(
  parameter int                    DATA_WIDTH   = 32,
  parameter logic [DATA_WIDTH-1:0] RESET_VECTOR = '0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  stall,
  input  logic                  valid_ex,
  input  logic                  branch,
  input  logic                  jump,
  input  logic                  jalr,
  input  logic [2:0]            funct3,
  input  logic [DATA_WIDTH-1:0] pc_ex,
  input  logic [DATA_WIDTH-1:0] imm_ex,
  input  logic [DATA_WIDTH-1:0] alu_result,
  input  logic                  zero,
  input  logic                  signedsmaller,
  input  logic                  unsignedsmaller,
  output logic [DATA_WIDTH-1:0] pc,
  output logic [DATA_WIDTH-1:0] pc_plus4,
  output logic                  taken,
  output logic                  flush,
  output logic                  trap,
  output logic [DATA_WIDTH-1:0] trap_pc,
  output logic                  dbg_state
);

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_HALT = 1'b1
  } state_e;

  state_e                state_q, state_d;
  logic [DATA_WIDTH-1:0] pc_q, pc_d;
  logic [DATA_WIDTH-1:0] trap_pc_q, trap_pc_d;

  logic                  cond_met;
  logic                  ctl_req;
  logic                  taken_w;
  logic                  misaligned;
  logic [DATA_WIDTH-1:0] br_target;
  logic [DATA_WIDTH-1:0] jalr_target;
  logic [DATA_WIDTH-1:0] target;

  // Flags come from a SUB of rs1 - rs2 issued by decode for every branch.
  always_comb begin
    cond_met = 1'b0;
    case (funct3)
      3'b000:  cond_met = zero;
      3'b001:  cond_met = ~zero;
      3'b100:  cond_met = signedsmaller;
      3'b101:  cond_met = ~signedsmaller;
      3'b110:  cond_met = unsignedsmaller;
      3'b111:  cond_met = ~unsignedsmaller;
      default: cond_met = 1'b0;
    endcase
  end

  assign br_target   = pc_ex + imm_ex;
  assign jalr_target = {alu_result[DATA_WIDTH-1:1], 1'b0};

  // JALR outranks JAL and branches when decode raises more than one.
  always_comb begin
    target = br_target;
    if (jalr) begin
      target = jalr_target;
    end
  end

  // valid_ex qualifies every EX field; with it low the flags are don't-care.
  assign ctl_req    = jalr | jump | (branch & cond_met);
  assign taken_w    = valid_ex & ctl_req & (state_q == ST_RUN);
  assign misaligned = taken_w & (target[1:0] != 2'b00);

  assign pc_plus4 = pc_q + DATA_WIDTH'(4);

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    trap_pc_d = trap_pc_q;
    case (state_q)
      ST_RUN: begin
        if (misaligned) begin
          state_d   = ST_HALT;
          trap_pc_d = pc_ex;
        end else if (taken_w) begin
          pc_d = target;
        end else if (!stall) begin
          pc_d = pc_plus4;
        end
      end
      ST_HALT: begin
        state_d = ST_HALT;
      end
      default: begin
        state_d = ST_HALT;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_RUN;
      pc_q      <= RESET_VECTOR;
      trap_pc_q <= '0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      trap_pc_q <= trap_pc_d;
    end
  end

  assign pc        = pc_q;
  assign taken     = taken_w;
  assign flush     = taken_w | misaligned | (state_q == ST_HALT);
  assign trap      = (state_q == ST_HALT);
  assign trap_pc   = trap_pc_q;
  assign dbg_state = (state_q == ST_HALT);

  a_halt_quiet: assert property (@(posedge clk) disable iff (!rst_n)
    (state_q == ST_HALT) |-> (flush && !taken));

  a_halt_sticky: assert property (@(posedge clk) disable iff (!rst_n)
    (state_q == ST_HALT) |=> (state_q == ST_HALT));

  a_halt_pc_frozen: assert property (@(posedge clk) disable iff (!rst_n)
    (state_q == ST_HALT) |=> (pc_q == $past(pc_q)));

  a_redirect: assert property (@(posedge clk) disable iff (!rst_n)
    (taken_w && !misaligned) |=> (pc_q == $past(target)));

endmodule

// File: tb/tb_pc_branch_unit.sv
// Bench for pc_branch_unit: vector table, hand-written corner sequences and
// randomized traffic checked against a behavioural PC/branch model.
module tb_pc_branch_unit;

  localparam logic [31:0] RV = 32'h0000_0100;

  logic        clk;
  logic        rst_n;
  logic        stall, valid_ex, branch, jump, jalr;
  logic [2:0]  funct3;
  logic [31:0] pc_ex, imm_ex, alu_result;
  logic        zero, signedsmaller, unsignedsmaller;
  logic [31:0] pc, pc_plus4, trap_pc;
  logic        taken, flush, trap, dbg_state;

  int checks = 0;
  int errors = 0;

  // behavioural model state
  logic [31:0] m_pc;
  logic        m_halt;
  logic [31:0] m_trap_pc;

  pc_branch_unit #(.DATA_WIDTH(32), .RESET_VECTOR(RV)) dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .valid_ex(valid_ex),
    .branch(branch), .jump(jump), .jalr(jalr), .funct3(funct3),
    .pc_ex(pc_ex), .imm_ex(imm_ex), .alu_result(alu_result),
    .zero(zero), .signedsmaller(signedsmaller), .unsignedsmaller(unsignedsmaller),
    .pc(pc), .pc_plus4(pc_plus4), .taken(taken), .flush(flush),
    .trap(trap), .trap_pc(trap_pc), .dbg_state(dbg_state)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic        v, b, j, jr;
    logic [2:0]  f3;
    logic        z, s, u, st;
    logic [31:0] pe, im, alu;
    logic        et;
    logic [31:0] etgt;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  function automatic logic cond_of(input logic [2:0] f3, input logic z, s, u);
    case (f3)
      3'd0:    return z;
      3'd1:    return !z;
      3'd4:    return s;
      3'd5:    return !s;
      3'd6:    return u;
      3'd7:    return !u;
      default: return 1'b0;
    endcase
  endfunction

  task automatic drive(input logic v, b, j, jr, input logic [2:0] f3,
                       input logic z, s, u, input logic [31:0] pe, im, alu,
                       input logic st);
    valid_ex = v; branch = b; jump = j; jalr = jr; funct3 = f3;
    zero = z; signedsmaller = s; unsignedsmaller = u;
    pc_ex = pe; imm_ex = im; alu_result = alu; stall = st;
  endtask

  task automatic idle();
    drive(0, 0, 0, 0, 3'd0, 0, 0, 0, 32'h0, 32'h0, 32'h0, 0);
  endtask

  // Called at a negedge with inputs driven; returns at the following negedge.
  task automatic run_cycle();
    logic        e_taken, e_flush, e_mis;
    logic [31:0] tgt, n_pc;
    #1;
    if (m_halt) begin
      e_taken = 0; e_flush = 1; e_mis = 0; n_pc = m_pc;
    end else begin
      e_taken = valid_ex && (jalr || jump || (branch && cond_of(funct3, zero, signedsmaller, unsignedsmaller)));
      tgt     = jalr ? (alu_result & ~32'd1) : (pc_ex + imm_ex);
      e_mis   = e_taken && (tgt % 4 != 0);
      e_flush = e_taken;
      if (e_mis)        n_pc = m_pc;
      else if (e_taken) n_pc = tgt;
      else if (stall)   n_pc = m_pc;
      else              n_pc = m_pc + 4;
    end
    chk("taken", {31'b0, taken}, {31'b0, e_taken});
    chk("flush", {31'b0, flush}, {31'b0, e_flush});
    chk("pc_plus4", pc_plus4, m_pc + 32'd4);
    @(posedge clk);
    #1;
    if (e_mis) begin
      m_halt    = 1;
      m_trap_pc = pc_ex;
    end
    m_pc = n_pc;
    chk("pc", pc, m_pc);
    chk("trap", {31'b0, trap}, {31'b0, m_halt});
    chk("trap_pc", trap_pc, m_trap_pc);
    chk("dbg_state", {31'b0, dbg_state}, {31'b0, m_halt});
    @(negedge clk);
  endtask

  // Called at a negedge; asserts reset with no clock edge before checking.
  task automatic do_reset();
    idle();
    rst_n = 0;
    #1;
    m_pc = RV; m_halt = 0; m_trap_pc = 32'h0;
    chk("rst_pc", pc, RV);
    chk("rst_trap", {31'b0, trap}, 32'h0);
    chk("rst_trap_pc", trap_pc, 32'h0);
    chk("rst_taken", {31'b0, taken}, 32'h0);
    chk("rst_flush", {31'b0, flush}, 32'h0);
    @(negedge clk);
    rst_n = 1;
  endtask

  initial begin
    logic [31:0] exp_pc;
    rst_n = 0;
    idle();
    m_pc = RV; m_halt = 0; m_trap_pc = 0;

    vecs.push_back('{1,1,0,0,3'd1,0,0,0,0, 32'h20,  32'hFFFF_FFF8, 32'h0,   1, 32'h18});
    vecs.push_back('{1,1,0,0,3'd1,1,0,0,0, 32'h20,  32'hFFFF_FFF8, 32'h0,   0, 32'h0});
    vecs.push_back('{1,1,0,0,3'd0,1,0,0,0, 32'h100, 32'h40,        32'h0,   1, 32'h140});
    vecs.push_back('{1,1,0,0,3'd0,0,1,1,0, 32'h100, 32'h40,        32'h0,   0, 32'h0});
    vecs.push_back('{1,1,0,0,3'd4,0,1,0,0, 32'h200, 32'h10,        32'h0,   1, 32'h210});
    vecs.push_back('{1,1,0,0,3'd4,0,0,1,0, 32'h200, 32'h10,        32'h0,   0, 32'h0});
    vecs.push_back('{1,1,0,0,3'd5,0,1,0,0, 32'h300, 32'hFFFF_FF00, 32'h0,   0, 32'h0});
    vecs.push_back('{1,1,0,0,3'd5,0,0,1,0, 32'h300, 32'hFFFF_FF00, 32'h0,   1, 32'h200});
    vecs.push_back('{1,1,0,0,3'd6,0,0,1,0, 32'h400, 32'h8,         32'h0,   1, 32'h408});
    vecs.push_back('{1,1,0,0,3'd6,0,1,0,0, 32'h400, 32'h8,         32'h0,   0, 32'h0});
    vecs.push_back('{1,1,0,0,3'd7,0,0,1,0, 32'h40,  32'h4,         32'h0,   0, 32'h0});
    vecs.push_back('{1,1,0,0,3'd7,0,1,0,0, 32'h40,  32'h4,         32'h0,   1, 32'h44});
    vecs.push_back('{1,1,0,0,3'd2,1,1,1,0, 32'h40,  32'h4,         32'h0,   0, 32'h0});
    vecs.push_back('{1,1,0,0,3'd3,0,0,0,0, 32'h40,  32'h4,         32'h0,   0, 32'h0});
    vecs.push_back('{0,0,1,0,3'd0,0,0,0,0, 32'h40,  32'h40,        32'h0,   0, 32'h0});
    vecs.push_back('{0,1,0,1,3'd0,1,0,0,0, 32'h40,  32'h40,        32'h400, 0, 32'h0});
    vecs.push_back('{1,0,1,0,3'd0,0,0,0,1, 32'h20,  32'h20,        32'h0,   1, 32'h40});
    vecs.push_back('{1,1,0,0,3'd0,0,0,0,1, 32'h20,  32'h20,        32'h0,   0, 32'h0});
    vecs.push_back('{0,0,0,0,3'd0,0,0,0,1, 32'h0,   32'h0,         32'h0,   0, 32'h0});
    vecs.push_back('{1,0,1,1,3'd0,0,0,0,0, 32'h500, 32'h0,         32'h304, 1, 32'h304});
    vecs.push_back('{1,0,0,1,3'd0,0,0,0,0, 32'h500, 32'h0,         32'h301, 1, 32'h300});
    vecs.push_back('{1,1,1,0,3'd2,0,0,0,0, 32'h60,  32'h20,        32'h0,   1, 32'h80});

    @(negedge clk);
    do_reset();

    for (int i = 0; i < 3; i++) run_cycle();
    chk("reset_idle_pc", pc, 32'h10C);

    foreach (vecs[i]) begin
      drive(vecs[i].v, vecs[i].b, vecs[i].j, vecs[i].jr, vecs[i].f3, vecs[i].z,
            vecs[i].s, vecs[i].u, vecs[i].pe, vecs[i].im, vecs[i].alu, vecs[i].st);
      #1;
      chk($sformatf("vec%0d_taken", i), {31'b0, taken}, {31'b0, vecs[i].et});
      chk($sformatf("vec%0d_flush", i), {31'b0, flush}, {31'b0, vecs[i].et});
      exp_pc = vecs[i].et ? vecs[i].etgt : (vecs[i].st ? m_pc : m_pc + 32'd4);
      run_cycle();
      chk($sformatf("vec%0d_pc", i), pc, exp_pc);
    end

    // stall holds for exactly the stalled cycles
    exp_pc = m_pc;
    drive(0, 0, 0, 0, 3'd0, 0, 0, 0, 32'h0, 32'h0, 32'h0, 1);
    run_cycle();
    run_cycle();
    chk("stall2_pc", pc, exp_pc);
    idle();
    run_cycle();
    chk("stall_release_pc", pc, exp_pc + 32'd4);

    // misaligned JALR halts, HALT ignores inputs, async reset recovers
    exp_pc = m_pc;
    drive(1, 0, 0, 1, 3'd0, 0, 0, 0, 32'h80, 32'h0, 32'h0000_0203, 0);
    #1;
    chk("mis_taken", {31'b0, taken}, 32'h1);
    chk("mis_flush", {31'b0, flush}, 32'h1);
    run_cycle();
    chk("mis_trap", {31'b0, trap}, 32'h1);
    chk("mis_trap_pc", trap_pc, 32'h80);
    chk("mis_pc_held", pc, exp_pc);
    for (int i = 0; i < 3; i++) begin
      drive(1, 1, 1, 0, 3'd0, 1, 0, 0, 32'h10, 32'h40, 32'h0, 0);
      run_cycle();
    end
    chk("halt_flush", {31'b0, flush}, 32'h1);
    chk("halt_pc", pc, exp_pc);
    do_reset();
    run_cycle();
    chk("after_halt_pc", pc, RV + 32'd4);

    // JAL with bit0 set in the target also halts
    drive(1, 0, 1, 0, 3'd0, 0, 0, 0, 32'h10, 32'h5, 32'h0, 0);
    run_cycle();
    chk("jal_odd_trap", {31'b0, trap}, 32'h1);
    chk("jal_odd_trap_pc", trap_pc, 32'h10);
    do_reset();

    // PC wraparound and branch target wraparound
    drive(1, 0, 1, 0, 3'd0, 0, 0, 0, 32'h0, 32'hFFFF_FFFC, 32'h0, 0);
    run_cycle();
    chk("wrap_setup_pc", pc, 32'hFFFF_FFFC);
    chk("wrap_plus4", pc_plus4, 32'h0);
    idle();
    run_cycle();
    chk("wrap_pc", pc, 32'h0);
    drive(1, 1, 0, 0, 3'd0, 1, 0, 0, 32'hFFFF_FFF0, 32'h20, 32'h0, 0);
    run_cycle();
    chk("wrap_branch_pc", pc, 32'h10);

    // randomized traffic against the model
    for (int n = 0; n < 600; n++) begin
      logic [31:0] r_alu, r_im, r_pe;
      if (m_halt && $urandom_range(0, 3) == 0) begin
        do_reset();
      end
      r_pe  = $urandom & ~32'd3;
      r_im  = $urandom;
      r_alu = $urandom;
      if ($urandom_range(0, 15) != 0) r_im  = r_im & ~32'd3;
      if ($urandom_range(0, 15) != 0) r_alu = r_alu & ~32'd2;
      drive($urandom_range(0, 3) != 0, 1'($urandom), ($urandom_range(0, 5) == 0),
            ($urandom_range(0, 7) == 0), 3'($urandom), 1'($urandom), 1'($urandom),
            1'($urandom), r_pe, r_im, r_alu, ($urandom_range(0, 3) == 0));
      run_cycle();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
